// File: rtl/reg_scoreboard.sv
// Issue-stage register scoreboard: per-register pending-write counters, RAW/WAW/full stalls,
// retire checking and a drain handshake. Define SB_BYPASS_EN to let a same-cycle retire satisfy RAW.
module reg_scoreboard #(
  parameter int unsigned NUM_REGS     = 16,
  parameter int unsigned CNT_W        = 2,
  parameter int unsigned MAX_INFLIGHT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                issue_valid,
  input  logic [4:0]          issue_rs,
  input  logic [4:0]          issue_rt,
  input  logic [4:0]          issue_rd,
  input  logic                issue_wen,
  output logic                issue_ready,
  output logic                enable_ab,
  input  logic                wb_valid,
  input  logic [4:0]          wb_rd,
  output logic                enable_c,
  input  logic                drain_req,
  output logic                drain_done,
  output logic [NUM_REGS-1:0] busy,
  output logic                err
);

  localparam int unsigned AW = 5;
  localparam int unsigned OW = $clog2(MAX_INFLIGHT + 1);
  localparam logic [AW:0]       NumRegsA = (AW + 1)'(NUM_REGS);
  localparam logic [CNT_W-1:0]  CntMax   = '1;
  localparam logic [CNT_W-1:0]  CntOne   = CNT_W'(1);
  localparam logic [OW-1:0]     OutMax   = OW'(MAX_INFLIGHT);
  localparam logic [OW-1:0]     OutOne   = OW'(1);

  localparam logic [1:0] StRun   = 2'd0;
  localparam logic [1:0] StDrain = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  logic [NUM_REGS-1:0][CNT_W-1:0] pending_q, pending_d;
  logic [OW-1:0]                  outstanding_q, outstanding_d;
  logic [1:0]                     state_q, state_d;
  logic [NUM_REGS-1:0]            busy_q, busy_d;
  logic                           drain_done_q, err_q, err_d;

  logic [CNT_W-1:0] pend_rs, pend_rt, pend_rd, pend_wb;
  logic rs_ok, rt_ok, rd_ok, wb_ok;
  logic retire, byp_rs, byp_rt, raw, waw, full, bad, inc;

  // Out-of-range addresses read a zero count; they are caught by the legality checks instead.
  always_comb begin
    pend_rs = '0;
    pend_rt = '0;
    pend_rd = '0;
    pend_wb = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (issue_rs == AW'(i)) pend_rs = pending_q[i];
      if (issue_rt == AW'(i)) pend_rt = pending_q[i];
      if (issue_rd == AW'(i)) pend_rd = pending_q[i];
      if (wb_rd == AW'(i))    pend_wb = pending_q[i];
    end
  end

  assign rs_ok  = {1'b0, issue_rs} < NumRegsA;
  assign rt_ok  = {1'b0, issue_rt} < NumRegsA;
  assign rd_ok  = {1'b0, issue_rd} < NumRegsA;
  assign wb_ok  = {1'b0, wb_rd} < NumRegsA;
  assign retire = wb_valid & wb_ok & (pend_wb != '0);

`ifdef SB_BYPASS_EN
  // Regfile writes on negedge, so a source whose last write retires now reads fresh data.
  assign byp_rs = retire & (wb_rd == issue_rs) & (pend_rs == CntOne);
  assign byp_rt = retire & (wb_rd == issue_rt) & (pend_rt == CntOne);
`else
  assign byp_rs = 1'b0;
  assign byp_rt = 1'b0;
`endif

  assign raw  = ((pend_rs != '0) & ~byp_rs) | ((pend_rt != '0) & ~byp_rt);
  assign waw  = issue_wen & (pend_rd == CntMax);
  assign full = issue_wen & (outstanding_q == OutMax);
  assign bad  = ~rs_ok | ~rt_ok | (issue_wen & ~rd_ok);

  assign issue_ready = (state_q == StRun) & ~raw & ~waw & ~full & ~bad;
  assign enable_ab   = issue_valid & issue_ready;
  assign enable_c    = retire;
  assign inc         = enable_ab & issue_wen;

  always_comb begin
    pending_d = pending_q;
    busy_d    = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (inc && (issue_rd == AW'(i))) pending_d[i] = pending_d[i] + CntOne;
      if (retire && (wb_rd == AW'(i))) pending_d[i] = pending_d[i] - CntOne;
      busy_d[i] = (pending_d[i] != '0);
    end

    case ({inc, retire})
      2'b10:   outstanding_d = outstanding_q + OutOne;
      2'b01:   outstanding_d = outstanding_q - OutOne;
      default: outstanding_d = outstanding_q;
    endcase

    err_d = err_q | (issue_valid & bad) | (wb_valid & ~retire);

    state_d = state_q;
    case (state_q)
      StRun: begin
        if (drain_req) state_d = StDrain;
      end
      StDrain: begin
        if (!drain_req)                state_d = StRun;
        else if (outstanding_d == '0)  state_d = StDone;
      end
      StDone: begin
        if (!drain_req) state_d = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q     <= '0;
      outstanding_q <= '0;
      state_q       <= StRun;
      busy_q        <= '0;
      drain_done_q  <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      pending_q     <= pending_d;
      outstanding_q <= outstanding_d;
      state_q       <= state_d;
      busy_q        <= busy_d;
      drain_done_q  <= (state_d == StDone);
      err_q         <= err_d;
    end
  end

  assign busy       = busy_q;
  assign drain_done = drain_done_q;
  assign err        = err_q;

endmodule
